mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive dbus grants after which a pending ibus request wins.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port ireq  in  ibus_req_t  fetch request; fields valid and addr[63:0].
REQ-005 SHALL have port iresp  out  ibus_resp_t  fetch response; fields addr_ok, data_ok and data[31:0].
REQ-006 SHALL have port dreq  in  dbus_req_t  memory-stage request; fields valid, addr[63:0], size[2:0], strobe[7:0] and data[63:0].
REQ-007 SHALL have port dresp  out  dbus_resp_t  memory-stage response; fields addr_ok, data_ok and data[63:0].
REQ-008 SHALL have port creq  out  cbus_req_t  shared-port request; fields valid, is_write, size[2:0], addr[63:0], strobe[7:0] and data[63:0].
REQ-009 SHALL have port cresp  in  cbus_resp_t  shared-port response; fields ready, last and data[63:0].

Function
REQ-010 SHALL implement three states: IDLE, GNT_I and GNT_D.
REQ-011 In IDLE, grant selection SHALL be:
- dreq.valid and not starved: go to GNT_D.
- else if ireq.valid: go to GNT_I.
- else stay in IDLE.
REQ-012 "Starved" SHALL mean starve_cnt == STARVE_LIMIT and ireq.valid; in that case the grant goes to GNT_I even if dreq.valid.
REQ-013 starve_cnt SHALL update on each grant edge:
- increment (saturating at STARVE_LIMIT) on a dbus grant while ireq.valid;
- clear on any ibus grant;
- clear on a dbus grant while ireq is idle.
REQ-014 On the grant edge, the arbiter SHALL latch the winner's request into a hold register; creq SHALL be driven only from that register.
REQ-015 A requester changing or dropping valid during a grant SHALL be ignored; the latched transaction completes.
REQ-016 In GNT_x, creq.valid SHALL be 1.
REQ-017 A latched ibus transaction SHALL drive creq.is_write=0, creq.size=3'b010 and creq.strobe=0.
REQ-018 A latched dbus transaction SHALL drive creq.is_write = (strobe != 0).
REQ-019 Completion SHALL be cresp.ready & cresp.last in GNT_x; in that same cycle, combinationally, the granted side gets addr_ok=data_ok=1.
REQ-020 On completion, iresp.data SHALL be cresp.data[31:0] when addr[2]=0 and cresp.data[63:32] when addr[2]=1; dresp.data SHALL be cresp.data.
REQ-021 On completion the state SHALL return to IDLE on the next edge.
REQ-022 Minimum latency SHALL be 1 cycle from request to creq.valid; back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-023 The non-granted side SHALL see addr_ok=data_ok=0 and data=0 at all times.
REQ-024 cresp.ready without last SHALL hold the current state; no multi-beat data is forwarded.
REQ-025 cresp activity in IDLE SHALL be ignored.
REQ-026 If ireq.valid and dreq.valid rise in the same cycle with starve_cnt < STARVE_LIMIT, dbus SHALL win.

Reset
REQ-027 While rst=1, the state SHALL be IDLE, starve_cnt 0 and the hold register 0.
REQ-028 While rst=1, creq, iresp and dresp SHALL all be 0.
REQ-029 Reset asserted mid-grant SHALL abandon the transaction; creq.valid=0 in the cycle after the reset edge and no response is issued.

Structure
REQ-030 The shared common package SHALL hold:
- ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, cbus_req_t and cbus_resp_t;
- the arbiter state enum;
- the MSIZE4 constant (3'b010).
REQ-031 The arbiter SHALL be a single module with no sub-modules; the datapath's ireq/dreq ports connect to it and its creq/cresp connect to the memory model.

Verification
REQ-032 Idle to ibus: ireq.valid addr=0x8000_0004 with ready&last one cycle after valid, cresp.data=0xAAAA_BBBB_CCCC_DDDD -> creq.valid at cycle 1 with size=010; iresp.data_ok=1 and iresp.data=0xAAAA_BBBB at cycle 1.
REQ-033 Simultaneous requests: ireq and dreq (strobe=0xFF, data=0x1122334455667788) both valid at cycle 0 -> dbus granted first with creq.is_write=1; ibus granted after one IDLE cycle.
REQ-034 Starvation: with STARVE_LIMIT=4, dreq and ireq held valid continuously -> grant order D,D,D,D,I,D…; starve_cnt clears after the I grant.
REQ-035 Held grant: dreq drops valid during GNT_D with ready held low for 5 cycles -> creq is unchanged for all 5 cycles; completion is delivered on dresp only; iresp stays 0.
REQ-036 Reset mid-grant: rst=1 during GNT_I with ready=0 -> next cycle creq.valid=0, state IDLE, no data_ok pulse on iresp.
REQ-037 Multi-beat guard: cresp.ready=1 with last=0 for 2 cycles, then last=1 -> data_ok pulses only on the last=1 cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types, arbiter state encoding and helper for the memory bus arbiter.
// Contents: ibus/dbus/cbus request and response payloads, arb_state_t, MSIZE4.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned IDATA_W = 32;
    localparam int unsigned DDATA_W = 64;
    localparam int unsigned STRB_W  = 8;
    localparam int unsigned SIZE_W  = 3;

    // Transfer size code for a 4-byte instruction fetch.
    localparam logic [SIZE_W-1:0] MSIZE4 = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [IDATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  addr;
        logic [SIZE_W-1:0]  size;
        logic [STRB_W-1:0]  strobe;
        logic [DDATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [DDATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [SIZE_W-1:0]  size;
        logic [ADDR_W-1:0]  addr;
        logic [STRB_W-1:0]  strobe;
        logic [DDATA_W-1:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [DDATA_W-1:0] data;
    } cbus_resp_t;

    // Pick the 32-bit half of a 64-bit beat addressed by addr[2].
    function automatic logic [IDATA_W-1:0] word_sel(
        input logic [DDATA_W-1:0] beat,
        input logic               hi
    );
        return hi ? beat[DDATA_W-1:IDATA_W] : beat[IDATA_W-1:0];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, memory-stage and shared-port buses around the arbiter.
// slave  : arbiter view (takes ireq/dreq/cresp, drives iresp/dresp/creq).
// master : environment view (datapath + memory model).
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport slave (
        input  ireq,
        input  dreq,
        input  cresp,
        output iresp,
        output dresp,
        output creq
    );

    modport master (
        output ireq,
        output dreq,
        output cresp,
        input  iresp,
        input  dresp,
        input  creq
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch (ibus)
// and the memory stage (dbus). dbus has priority until it has won STARVE_LIMIT
// consecutive grants against a waiting ibus, then ibus gets one grant.
// Ports: clk   - clock, rising edge
//        rst   - synchronous active-high reset
//        bus   - slave modport: ireq/dreq in, iresp/dresp out, creq out, cresp in
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    cbus_req_t        r_hold;
    cbus_req_t        w_hold_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic       w_starved;
    logic       w_done;
    cbus_req_t  w_creq;
    ibus_resp_t w_iresp;
    dbus_resp_t w_dresp;

    assign w_starved = (r_starve_cnt == CNT_MAX) && bus.ireq.valid;
    assign w_done    = bus.cresp.ready & bus.cresp.last;

    // State, hold register and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

    // Grant selection, request latching and response steering.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_cnt_nxt   = r_starve_cnt;
        w_creq      = '0;
        w_iresp     = '0;
        w_dresp     = '0;

        unique case (r_state)
            IDLE: begin
                if (bus.dreq.valid && !w_starved) begin
                    w_state_nxt         = GNT_D;
                    w_hold_nxt          = '0;
                    w_hold_nxt.valid    = 1'b1;
                    w_hold_nxt.is_write = |bus.dreq.strobe;
                    w_hold_nxt.size     = bus.dreq.size;
                    w_hold_nxt.addr     = bus.dreq.addr;
                    w_hold_nxt.strobe   = bus.dreq.strobe;
                    w_hold_nxt.data     = bus.dreq.data;
                    // Only count wins that actually kept a fetch waiting.
                    if (!bus.ireq.valid) begin
                        w_cnt_nxt = '0;
                    end else if (r_starve_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_starve_cnt + CNT_W'(1);
                    end
                end else if (bus.ireq.valid) begin
                    w_state_nxt      = GNT_I;
                    w_hold_nxt       = '0;
                    w_hold_nxt.valid = 1'b1;
                    w_hold_nxt.size  = MSIZE4;
                    w_hold_nxt.addr  = bus.ireq.addr;
                    w_cnt_nxt        = '0;
                end
            end
            GNT_I: begin
                w_creq = r_hold;
                // Intermediate beats (ready without last) are dropped.
                if (w_done) begin
                    w_iresp.addr_ok = 1'b1;
                    w_iresp.data_ok = 1'b1;
                    w_iresp.data    = word_sel(bus.cresp.data, r_hold.addr[2]);
                    w_state_nxt     = IDLE;
                end
            end
            GNT_D: begin
                w_creq = r_hold;
                if (w_done) begin
                    w_dresp.addr_ok = 1'b1;
                    w_dresp.data_ok = 1'b1;
                    w_dresp.data    = bus.cresp.data;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are quiet for the whole reset window, including the cycle
        // before the reset edge takes the state back to IDLE.
        if (rst) begin
            w_creq  = '0;
            w_iresp = '0;
            w_dresp = '0;
        end
    end

    assign bus.creq  = w_creq;
    assign bus.iresp = w_iresp;
    assign bus.dresp = w_dresp;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios, a configurable
// memory responder and a queue-based scoreboard for grants and completions.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct packed {
        logic        is_i;
        logic [63:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues and logs
    cbus_req_t exp_creq[$];
    sb_t       exp_resp[$];
    int        grant_cyc[$];
    int        done_cyc[$];
    int        starve_log[$];
    int        cyc = 0;

    // Memory responder knobs
    int          mem_lat    = 0;
    int          mem_nolast = 0;
    bit          mem_fixed  = 1'b0;
    bit          mem_noise  = 1'b0;
    logic [63:0] mem_fixed_data = 64'h0;

    function automatic logic [63:0] mdata(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_0000, ~a[31:0]};
    endfunction

    task automatic exp_i(input logic [63:0] a, input logic [63:0] beat, input bit with_resp);
        cbus_req_t c;
        sb_t       s;
        c          = '0;
        c.valid    = 1'b1;
        c.size     = 3'b010;
        c.addr     = a;
        exp_creq.push_back(c);
        s.is_i     = 1'b1;
        s.data     = a[2] ? {32'h0, beat[63:32]} : {32'h0, beat[31:0]};
        if (with_resp) exp_resp.push_back(s);
    endtask

    task automatic exp_d(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] strb,
                         input logic [63:0] wd, input logic [63:0] beat);
        cbus_req_t c;
        sb_t       s;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = (strb != 8'h0);
        c.size     = sz;
        c.addr     = a;
        c.strobe   = strb;
        c.data     = wd;
        exp_creq.push_back(c);
        s.is_i     = 1'b0;
        s.data     = beat;
        exp_resp.push_back(s);
    endtask

    // Memory model: answers the shared port after mem_lat idle cycles,
    // with mem_nolast ready-without-last beats before the final one.
    int rsp_k    = 0;
    bit rsp_prev = 1'b0;
    always @(posedge clk) begin
        #2;
        if (mem_noise) begin
            bus.cresp.ready = 1'b1;
            bus.cresp.last  = 1'b1;
            bus.cresp.data  = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (bus.creq.valid) begin
            if (!rsp_prev) rsp_k = 0;
            else           rsp_k++;
            bus.cresp.ready = (rsp_k >= mem_lat);
            bus.cresp.last  = (rsp_k >= mem_lat + mem_nolast);
            if (bus.cresp.last)
                bus.cresp.data = mem_fixed ? mem_fixed_data : mdata(bus.creq.addr);
            else
                bus.cresp.data = 64'h0BAD_0BAD_0BAD_0BAD;
        end else begin
            bus.cresp = '0;
        end
        rsp_prev = bus.creq.valid;
    end

    // Monitor: checks every new grant and every completion against the queues.
    bit        mon_prev_v = 1'b0;
    cbus_req_t mon_c;
    sb_t       mon_s;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.creq.valid && !mon_prev_v) begin
                grant_cyc.push_back(cyc);
                starve_log.push_back(int'(dut.r_starve_cnt));
                if (exp_creq.size() == 0) begin
                    check_eq("grant_unexpected", 160'(1), 160'(0));
                end else begin
                    mon_c = exp_creq.pop_front();
                    check_eq("grant_creq", 160'(bus.creq), 160'(mon_c));
                end
            end
            if (bus.iresp.data_ok || bus.dresp.data_ok) begin
                done_cyc.push_back(cyc);
                if (exp_resp.size() == 0) begin
                    check_eq("resp_unexpected", 160'(1), 160'(0));
                end else begin
                    mon_s = exp_resp.pop_front();
                    check_eq("resp_side", 160'(bus.iresp.data_ok), 160'(mon_s.is_i));
                    if (mon_s.is_i) begin
                        check_eq("iresp", 160'(bus.iresp), 160'({2'b11, mon_s.data[31:0]}));
                        check_eq("dresp_quiet", 160'(bus.dresp), 160'(0));
                    end else begin
                        check_eq("dresp", 160'(bus.dresp), 160'({2'b11, mon_s.data}));
                        check_eq("iresp_quiet", 160'(bus.iresp), 160'(0));
                    end
                end
            end
        end
        mon_prev_v = bus.creq.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_resp.size() == 0 && !bus.creq.valid) break;
        end
        check_eq("drain_resp", 160'(exp_resp.size()), 160'(0));
        check_eq("drain_creq", 160'(exp_creq.size()), 160'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int        base;
    int        dbase;
    cbus_req_t hold_c;
    int        exp_starve[6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        rst      = 1'b1;
        bus.ireq = '0;
        bus.dreq = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_creq",   160'(bus.creq),          160'(0));
        check_eq("rst_iresp",  160'(bus.iresp),         160'(0));
        check_eq("rst_dresp",  160'(bus.dresp),         160'(0));
        check_eq("rst_state",  160'(dut.r_state),       160'(IDLE));
        check_eq("rst_starve", 160'(dut.r_starve_cnt),  160'(0));
        check_eq("rst_hold",   160'(dut.r_hold),        160'(0));
        tick();
        rst = 1'b0;

        // Idle to ibus, single-cycle memory, upper word selected.
        mem_fixed      = 1'b1;
        mem_fixed_data = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0004;
        exp_i(64'h8000_0004, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        @(negedge clk);
        check_eq("t1_c0_valid", 160'(bus.creq.valid), 160'(0));
        tick();
        bus.ireq = '0;
        @(negedge clk);
        check_eq("t1_c1_valid",   160'(bus.creq.valid),   160'(1));
        check_eq("t1_c1_size",    160'(bus.creq.size),    160'(3'b010));
        check_eq("t1_c1_data_ok", 160'(bus.iresp.data_ok), 160'(1));
        check_eq("t1_c1_data",    160'(bus.iresp.data),   160'(32'hAAAA_BBBB));
        drain(20);
        mem_fixed = 1'b0;

        // Simultaneous requests: dbus write first, ibus after one idle cycle.
        base  = grant_cyc.size();
        dbase = done_cyc.size();
        bus.ireq.valid   = 1'b1;
        bus.ireq.addr    = 64'h8000_0010;
        bus.dreq.valid   = 1'b1;
        bus.dreq.addr    = 64'h1000_0020;
        bus.dreq.size    = 3'b011;
        bus.dreq.strobe  = 8'hFF;
        bus.dreq.data    = 64'h1122_3344_5566_7788;
        exp_d(64'h1000_0020, 3'b011, 8'hFF, 64'h1122_3344_5566_7788, mdata(64'h1000_0020));
        exp_i(64'h8000_0010, mdata(64'h8000_0010), 1'b1);
        tick();
        bus.dreq = '0;
        tick();
        tick();
        bus.ireq = '0;
        drain(20);
        check_eq("t2_gap",       160'(grant_cyc[base+1] - done_cyc[dbase]), 160'(2));
        check_eq("t2_starve_d",  160'(starve_log[base]),   160'(1));
        check_eq("t2_starve_i",  160'(starve_log[base+1]), 160'(0));

        // Starvation: both held, expect D,D,D,D,I,D.
        base = grant_cyc.size();
        bus.ireq.valid  = 1'b1;
        bus.ireq.addr   = 64'h8000_0100;
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h1000_0200;
        bus.dreq.size   = 3'b011;
        bus.dreq.strobe = 8'h00;
        bus.dreq.data   = 64'h0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) exp_i(64'h8000_0100, mdata(64'h8000_0100), 1'b1);
            else        exp_d(64'h1000_0200, 3'b011, 8'h00, 64'h0, mdata(64'h1000_0200));
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (grant_cyc.size() >= base + 6) break;
        end
        check_eq("t3_grants", 160'(grant_cyc.size() >= base + 6), 160'(1));
        tick();
        bus.ireq = '0;
        bus.dreq = '0;
        drain(20);
        for (int i = 0; i < 6; i++) begin
            if (starve_log.size() > base + i)
                check_eq($sformatf("t3_starve%0d", i), 160'(starve_log[base+i]), 160'(exp_starve[i]));
            else
                check_eq($sformatf("t3_starve%0d_missing", i), 160'(1), 160'(0));
        end

        // Held grant: dbus drops valid and changes address while memory stalls.
        base    = starve_log.size();
        mem_lat = 5;
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h1000_0300;
        bus.dreq.size   = 3'b010;
        bus.dreq.strobe = 8'h0F;
        bus.dreq.data   = 64'hCAFE_F00D_1234_5678;
        exp_d(64'h1000_0300, 3'b010, 8'h0F, 64'hCAFE_F00D_1234_5678, mdata(64'h1000_0300));
        hold_c          = '0;
        hold_c.valid    = 1'b1;
        hold_c.is_write = 1'b1;
        hold_c.size     = 3'b010;
        hold_c.addr     = 64'h1000_0300;
        hold_c.strobe   = 8'h0F;
        hold_c.data     = 64'hCAFE_F00D_1234_5678;
        tick();
        bus.dreq.valid = 1'b0;
        bus.dreq.addr  = 64'h1000_0FF8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_creq%0d", i),  160'(bus.creq),  160'(hold_c));
            check_eq($sformatf("t5_iresp%0d", i), 160'(bus.iresp), 160'(0));
        end
        drain(20);
        bus.dreq = '0;
        check_eq("t5_starve_clr", 160'(starve_log[base]), 160'(0));

        // Reset during an ibus grant: transaction abandoned, no response.
        mem_lat = 10;
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0400;
        exp_i(64'h8000_0400, 64'h0, 1'b0);
        tick();
        bus.ireq = '0;
        @(negedge clk);
        check_eq("t6_granted", 160'(bus.creq.valid), 160'(1));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_creq",  160'(bus.creq.valid), 160'(0));
        check_eq("t6_rst_iresp", 160'(bus.iresp),      160'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_post_valid", 160'(bus.creq.valid),    160'(0));
        check_eq("t6_post_state", 160'(dut.r_state),       160'(IDLE));
        check_eq("t6_post_dok",   160'(bus.iresp.data_ok), 160'(0));
        repeat (12) @(negedge clk);
        #1;
        check_eq("t6_no_resp", 160'(exp_resp.size()), 160'(0));
        check_eq("t6_no_creq", 160'(exp_creq.size()), 160'(0));
        tick();
        mem_lat = 0;

        // Multi-beat guard: two ready-without-last beats, then last.
        mem_nolast = 2;
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h1000_0500;
        bus.dreq.size   = 3'b011;
        bus.dreq.strobe = 8'h00;
        bus.dreq.data   = 64'h0;
        exp_d(64'h1000_0500, 3'b011, 8'h00, 64'h0, mdata(64'h1000_0500));
        tick();
        bus.dreq = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t7_valid%0d", i), 160'(bus.creq.valid),    160'(1));
            check_eq($sformatf("t7_dok%0d", i),   160'(bus.dresp.data_ok), 160'(i == 2));
        end
        drain(20);
        mem_nolast = 0;

        // Memory-side activity while idle must not produce responses.
        mem_noise = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t8_iresp%0d", i), 160'(bus.iresp), 160'(0));
            check_eq($sformatf("t8_dresp%0d", i), 160'(bus.dresp), 160'(0));
            check_eq($sformatf("t8_creq%0d", i),  160'(bus.creq),  160'(0));
        end
        tick();
        mem_noise = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
